net_frontend: RTL and testbench
===============================

// Module: net_frontend
// PURPOSE
//  Host-side sequencer directly upstream of the network processor. Accepts one
//  image as a valid/ready byte stream and converts each pixel from uint8 to int8.
//  Clears and fills the processor's data memory, pulses its start, waits for done,
//  then holds the 4-bit class result until the host acknowledges it.
// PARAMETERS
//  NUM_INPUTS   784      bytes per image written to data memory
//  PIX_SIGNED   0        0: pixel ^ 8'h80 (uint8 -> int8, x-128); 1: pass through
//  TIMEOUT      2**20    max cycles in RUN before the inference is abandoned
// PORTS
//  clk           in   1  clock
//  rst_n         in   1  synchronous active-low reset
//  in_valid      in   1  host byte valid
//  in_data       in   8  host pixel byte
//  in_ready      out  1  frontend accepts in_data this cycle
//  res_valid     out  1  result (or error) available
//  res_class     out  4  predicted class 0..9
//  res_err       out  1  1 = timeout; res_class is 0
//  res_ready     in   1  host consumes result
//  busy          out  1  high in every state except IDLE
//  np_mem_rst    out  1  to processor ext_mem_rst
//  np_mem_we     out  1  to processor ext_mem_we
//  np_mem_wdata  out  8  to processor ext_mem_wdata
//  np_start      out  1  to processor start
//  np_done       in   1  from processor done (level, cleared by start)
//  np_max_idx    in   4  from processor max_idx_10
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE. All outputs 0 except np_mem_rst=1,
//   which holds processor memory and run state cleared. Counters are zeroed.
//   Reset mid-transfer or mid-run abandons the image; no partial result is given.
//  States:
//   IDLE  : in_ready=0. When in_valid=1, go to CLR without consuming the byte.
//   CLR   : np_mem_rst=1 for exactly 1 cycle; cnt<=0; go to LOAD.
//   LOAD  : in_ready=1. On each in_valid&in_ready, in the same cycle:
//           np_mem_we=1; np_mem_wdata = PIX_SIGNED ? in_data : in_data^8'h80;
//           cnt++. The beat with cnt==NUM_INPUTS-1 goes to START; in_ready drops
//           the next cycle. Bubbles (in_valid=0) are allowed, with we=0.
//   START : np_start=1 for 1 cycle; tmo<=0; go to GUARD.
//   GUARD : 1 cycle. np_done is ignored here because the processor clears it
//           on the cycle after start. Go to RUN.
//   RUN   : tmo++ each cycle. If np_done=1: res_class<=np_max_idx, res_err<=0,
//           go to REPORT. Else if tmo==TIMEOUT-1: res_class<=0, res_err<=1,
//           np_mem_rst=1 for 1 cycle, go to REPORT. If done and timeout occur
//           in the same cycle, done wins.
//   REPORT: res_valid=1, and res_class/res_err are held stable. On res_ready=1,
//           go to IDLE with res_valid=0 the next cycle. in_ready stays 0, so
//           host bytes stall until the result is taken.
//  Handshake: a beat transfers only on in_valid&in_ready. res_valid never drops
//   without res_ready. A new image starts at the earliest 1 cycle after ack.
//  Latency: the first byte is written 2 cycles after in_valid rises in IDLE.
//   np_start rises 1 cycle after the last write.
//  Width: cnt is $clog2(NUM_INPUTS) bits and never wraps, since it resets in CLR.
//   tmo is $clog2(TIMEOUT) bits.
//  np_mem_we and np_mem_rst are never high together. np_start is high only in START.
// TESTING
//  1. Reset, then 784 bytes 0x00..0x0F repeated, no bubbles -> mem_rst pulse,
//     784 writes of wdata=byte^0x80 (0x80,0x81,...), then one np_start pulse.
//  2. Model drives np_done=1 with max_idx=7 at 50 cycles after start, res_ready
//     held 0 for 10 cycles -> res_valid=1, class=7, err=0, stable 10 cycles,
//     then IDLE.
//  3. Random in_valid bubbles at 30% -> exactly 784 writes, data order preserved,
//     no write on bubble cycles.
//  4. Stale np_done=1 held through START -> GUARD ignores it. The result is taken
//     only after the model drops done and re-raises it with max_idx=3.
//  5. TIMEOUT=64, np_done never rises -> at cycle 64 of RUN: res_err=1, class=0,
//     one mem_rst pulse.
//  6. rst_n=0 after 400 bytes -> IDLE, np_mem_rst=1, no start. The next image
//     completes normally with a class result.

Source files
------------

// File: rtl/net_frontend.sv
// Host-side sequencer for the network processor: streams one image into
// its data memory as int8, runs it, and holds the class until acknowledged.
module net_frontend #(
  parameter int NUM_INPUTS = 784,
  parameter bit PIX_SIGNED = 1'b0,
  parameter int TIMEOUT    = 2**20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       res_valid,
  output logic [3:0] res_class,
  output logic       res_err,
  input  logic       res_ready,
  output logic       busy,
  output logic       np_mem_rst,
  output logic       np_mem_we,
  output logic [7:0] np_mem_wdata,
  output logic       np_start,
  input  logic       np_done,
  input  logic [3:0] np_max_idx
);

  localparam int CW = $clog2(NUM_INPUTS);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_INPUTS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    START,
    GUARD,
    RUN,
    REPORT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic          fire;
  logic          tmo_hit;

  // Decodes are gated by rst_n so every output is quiet while reset is held.
  assign in_ready  = rst_n & (state == LOAD);
  assign fire      = in_valid & in_ready;
  assign np_mem_we = fire;
  assign np_start  = rst_n & (state == START);
  assign res_valid = rst_n & (state == REPORT);
  assign busy      = rst_n & (state != IDLE);

  assign np_mem_wdata = !fire      ? 8'h00 :
                        PIX_SIGNED ? in_data :
                                     in_data ^ 8'h80;

  // An abandoned run also wipes the processor so it is not left mid-inference.
  assign tmo_hit = rst_n & (state == RUN) & ~np_done & (tmo == TMO_LAST);

  assign np_mem_rst = ~rst_n | (state == CLR) | tmo_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tmo       <= '0;
      res_class <= '0;
      res_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) state <= CLR;
        end
        CLR: begin
          cnt   <= '0;
          state <= LOAD;
        end
        LOAD: begin
          if (fire) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= START;
          end
        end
        START: begin
          tmo   <= '0;
          state <= GUARD;
        end
        GUARD: begin
          state <= RUN;
        end
        RUN: begin
          tmo <= tmo + 1'b1;
          if (np_done) begin
            res_class <= np_max_idx;
            res_err   <= 1'b0;
            state     <= REPORT;
          end else if (tmo == TMO_LAST) begin
            res_class <= '0;
            res_err   <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_net_frontend.sv
// Directed bench for net_frontend: table of image scenarios plus
// hand-written reset and abort sequences.
module tb_net_frontend;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       res_valid;
  logic [3:0] res_class;
  logic       res_err;
  logic       res_ready;
  logic       busy;
  logic       np_mem_rst;
  logic       np_mem_we;
  logic [7:0] np_mem_wdata;
  logic       np_start;
  logic       np_done;
  logic [3:0] np_max_idx;

  net_frontend #(
    .NUM_INPUTS(784),
    .PIX_SIGNED(1'b0),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .res_valid(res_valid),
    .res_class(res_class),
    .res_err(res_err),
    .res_ready(res_ready),
    .busy(busy),
    .np_mem_rst(np_mem_rst),
    .np_mem_we(np_mem_we),
    .np_mem_wdata(np_mem_wdata),
    .np_start(np_start),
    .np_done(np_done),
    .np_max_idx(np_max_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       pmod;
    int       poff;
    int       bub;
    int       dly;
    logic [3:0] cls;
    bit       stale;
    int       hold;
    int       abort_n;
    logic [3:0] exp_cls;
    bit       exp_err;
    int       exp_lat;
    int       exp_rst;
  } vec_t;

  vec_t vecs[6];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int cur_mod = 16;
  int cur_off = 0;
  int wr_cnt, data_err, bub_err, start_cnt, rst_cyc, excl_err;
  int first_we, last_we, start_cyc, vrise;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int i);
    return 8'((i % cur_mod) + cur_off);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (np_mem_we) begin
        if (np_mem_wdata !== (pix(wr_cnt) ^ 8'h80)) data_err++;
        if (!in_valid) bub_err++;
        if (wr_cnt == 0) first_we = cyc;
        last_we = cyc;
        wr_cnt++;
      end
      if (np_mem_rst) rst_cyc++;
      if (np_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (np_mem_we && np_mem_rst) excl_err++;
    end
  end

  task automatic clr_mon();
    wr_cnt    = 0;
    data_err  = 0;
    bub_err   = 0;
    start_cnt = 0;
    rst_cyc   = 0;
    first_we  = -1;
    last_we   = -1;
    start_cyc = -1;
    vrise     = -1;
  endtask

  task automatic run_image(input int id, input vec_t v);
    int n, i, k, lat, stab;
    logic [3:0] c0;
    logic e0;
    string p;
    p = $sformatf("v%0d", id);
    cur_mod = v.pmod;
    cur_off = v.poff;
    n = (v.abort_n > 0) ? v.abort_n : 784;
    np_done = v.stale;
    np_max_idx = v.stale ? 4'd9 : 4'd0;
    @(negedge clk);
    clr_mon();
    i = 0;
    k = 0;
    while (i < n && k < 5000) begin
      @(negedge clk);
      k++;
      in_valid = ($urandom_range(99) >= v.bub);
      in_data = pix(i);
      if (in_valid && vrise < 0) vrise = cyc;
      if (in_valid && in_ready) i++;
    end
    chk({p, "_beats"}, i, n);
    @(negedge clk);
    in_valid = 1'b0;
    if (v.abort_n > 0) begin
      rst_n = 1'b0;
      @(negedge clk);
      chk({p, "_rst_memrst"}, np_mem_rst, 1);
      chk({p, "_rst_busy"}, busy, 0);
      chk({p, "_rst_ready"}, in_ready, 0);
      chk({p, "_rst_we"}, np_mem_we, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk({p, "_writes"}, wr_cnt, n);
      chk({p, "_no_start"}, start_cnt, 0);
      chk({p, "_idle_resv"}, res_valid, 0);
      return;
    end
    k = 0;
    while (!np_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({p, "_start_seen"}, np_start, 1);
    lat = -1;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (v.stale && t == 2) np_done = 1'b0;
      if (t == v.dly) begin
        np_done = 1'b1;
        np_max_idx = v.cls;
      end
      if (res_valid) begin
        lat = t;
        break;
      end
    end
    chk({p, "_res_lat"}, lat, v.exp_lat);
    chk({p, "_class"}, res_class, v.exp_cls);
    chk({p, "_err"}, res_err, v.exp_err);
    chk({p, "_writes"}, wr_cnt, 784);
    chk({p, "_wdata"}, data_err, 0);
    chk({p, "_bubble_we"}, bub_err, 0);
    chk({p, "_starts"}, start_cnt, 1);
    chk({p, "_memrst_cyc"}, rst_cyc, v.exp_rst);
    if (v.bub == 0) begin
      chk({p, "_first_we_lat"}, first_we - vrise, 2);
      chk({p, "_start_lat"}, start_cyc - last_we, 1);
    end
    c0 = res_class;
    e0 = res_err;
    stab = 0;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (!res_valid || res_class !== c0 || res_err !== e0) stab++;
    end
    chk({p, "_hold"}, stab, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({p, "_ack_resv"}, res_valid, 0);
    chk({p, "_ack_busy"}, busy, 0);
    np_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16, 0, 0, 50, 4'd7, 1'b0, 10, 0, 4'd7, 1'b0, 51, 1};
    vecs[1] = '{256, 51, 30, 20, 4'd2, 1'b0, 3, 0, 4'd2, 1'b0, 21, 1};
    vecs[2] = '{256, 5, 10, 10, 4'd3, 1'b1, 2, 0, 4'd3, 1'b0, 11, 1};
    vecs[3] = '{256, 200, 0, 0, 4'd5, 1'b0, 4, 0, 4'd0, 1'b1, 66, 2};
    vecs[4] = '{256, 17, 0, 0, 4'd0, 1'b0, 0, 400, 4'd0, 1'b0, 0, 0};
    vecs[5] = '{256, 128, 0, 2, 4'd9, 1'b0, 0, 0, 4'd9, 1'b0, 3, 1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    res_ready = 1'b0;
    np_done = 1'b0;
    np_max_idx = 4'd0;
    excl_err = 0;
    clr_mon();
    repeat (3) @(negedge clk);
    chk("reset_memrst", np_mem_rst, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", in_ready, 0);
    chk("reset_resv", res_valid, 0);
    chk("reset_class", res_class, 0);
    chk("reset_err", res_err, 0);
    chk("reset_start", np_start, 0);
    chk("reset_we", np_mem_we, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_memrst", np_mem_rst, 0);
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 6; v++) run_image(v, vecs[v]);

    chk("we_rst_excl", excl_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
